// File: rtl/cmd_pkg.sv
// Shared command definitions for the remote-side framer and the command configuration block.
// Latency: n/a (constants, types and a byte-select helper only).
// Backpressure: n/a.
package cmd_pkg;

  // Host opcodes understood by the quadcopter's command configuration block
  localparam logic [7:0] SET_PITCH = 8'h02;
  localparam logic [7:0] SET_ROLL  = 8'h03;
  localparam logic [7:0] SET_YAW   = 8'h04;
  localparam logic [7:0] SET_THRST = 8'h05;
  localparam logic [7:0] CALIBRATE = 8'h06;
  localparam logic [7:0] EMER_LAND = 8'h07;
  localparam logic [7:0] MTRS_OFF  = 8'h08;

  // Positive acknowledge returned by the quadcopter
  localparam logic [7:0] POS_ACK   = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    TX_CMD,
    TX_HI,
    TX_LO,
    WAIT_RESP
  } framer_state_t;

  // One host request as it is held while its frame is on the wire
  typedef struct packed {
    logic [7:0]  cmd;
    logic [15:0] data;
  } cmd_req_t;

  // Wire order of a frame: 0 = opcode, 1 = data MSB, 2 = data LSB
  function automatic logic [7:0] frame_byte(input cmd_req_t req, input logic [1:0] idx);
    logic [7:0] b;
    b = req.cmd;
    case (idx)
      2'd1:    b = req.data[15:8];
      2'd2:    b = req.data[7:0];
      default: b = req.cmd;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/cmd_framer_if.sv
// Bundles the framer's host, UART-tx and UART-rx handshakes.
// Latency: n/a (wires only).
// Backpressure: tx side is paced by trmt/tx_done; rx side by rx_rdy/clr_rx_rdy; host by busy.
// Ports: host    - snd_cmd, cmd, data -> busy, resp, resp_rdy, timeout
//        uart tx - tx_data, trmt -> tx_done
//        uart rx - rx_rdy, rx_data -> clr_rx_rdy
interface cmd_framer_if;
  logic        snd_cmd;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        busy;
  logic [7:0]  tx_data;
  logic        trmt;
  logic        tx_done;
  logic        rx_rdy;
  logic [7:0]  rx_data;
  logic        clr_rx_rdy;
  logic [7:0]  resp;
  logic        resp_rdy;
  logic        timeout;

  // The framer itself
  modport master (
    input  snd_cmd, cmd, data, tx_done, rx_rdy, rx_data,
    output busy, tx_data, trmt, clr_rx_rdy, resp, resp_rdy, timeout
  );

  // Host plus UART pair surrounding the framer
  modport slave (
    output snd_cmd, cmd, data, tx_done, rx_rdy, rx_data,
    input  busy, tx_data, trmt, clr_rx_rdy, resp, resp_rdy, timeout
  );
endinterface

// File: rtl/cmd_framer.sv
// Frames a host command as opcode/data-MSB/data-LSB over a UART tx handshake, then awaits a 1-byte response.
// Latency: first trmt one cycle after snd_cmd; each further byte one cycle after tx_done; response or timeout ends it.
// Backpressure: host is held off by busy (snd_cmd ignored while busy); bytes advance only on tx_done.
// Ports: clk, rst (async, active-high); bus (cmd_framer_if.master) carrying host, uart tx and uart rx signals.
module cmd_framer
  import cmd_pkg::*;
#(
  parameter bit FAST_SIM = 1'b1,
  parameter int TMR_W    = (FAST_SIM ? 10 : 27)
) (
  input  logic         clk,
  input  logic         rst,
  cmd_framer_if.master bus
);

  framer_state_t    state, state_nxt;
  cmd_req_t         req_q, req_nxt, req_in;
  logic [7:0]       tx_data_q, tx_data_nxt;
  logic             trmt_q, trmt_nxt;
  logic             clr_q, clr_nxt;
  logic [7:0]       resp_q, resp_nxt;
  logic             resp_rdy_q, resp_rdy_nxt;
  logic             timeout_q, timeout_nxt;
  logic [TMR_W-1:0] timer_q, timer_nxt, timer_inc;
  logic             tx_ack;

  assign req_in.cmd  = bus.cmd;
  assign req_in.data = bus.data;

  // A tx_done coinciding with our own trmt belongs to the previous byte, not this one
  assign tx_ack    = bus.tx_done & ~trmt_q;
  assign timer_inc = timer_q + TMR_W'(1);

  always_comb begin
    state_nxt    = state;
    req_nxt      = req_q;
    tx_data_nxt  = tx_data_q;
    trmt_nxt     = 1'b0;
    clr_nxt      = 1'b0;
    resp_nxt     = resp_q;
    resp_rdy_nxt = 1'b0;
    timeout_nxt  = 1'b0;
    timer_nxt    = timer_q;

    case (state)
      IDLE: begin
        // Anything sitting in the receiver now is stale: drop it
        clr_nxt = bus.rx_rdy;
        if (bus.snd_cmd) begin
          req_nxt     = req_in;
          tx_data_nxt = frame_byte(req_in, 2'd0);
          trmt_nxt    = 1'b1;
          state_nxt   = TX_CMD;
        end
      end
      TX_CMD: begin
        clr_nxt = bus.rx_rdy;
        if (tx_ack) begin
          tx_data_nxt = frame_byte(req_q, 2'd1);
          trmt_nxt    = 1'b1;
          state_nxt   = TX_HI;
        end
      end
      TX_HI: begin
        clr_nxt = bus.rx_rdy;
        if (tx_ack) begin
          tx_data_nxt = frame_byte(req_q, 2'd2);
          trmt_nxt    = 1'b1;
          state_nxt   = TX_LO;
        end
      end
      TX_LO: begin
        clr_nxt = bus.rx_rdy;
        if (tx_ack) begin
          timer_nxt = '0;
          state_nxt = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        timer_nxt = timer_inc;
        // A response arriving on the very cycle the window closes still counts
        if (bus.rx_rdy) begin
          resp_nxt     = bus.rx_data;
          resp_rdy_nxt = 1'b1;
          clr_nxt      = 1'b1;
          state_nxt    = IDLE;
        end else if (&timer_inc) begin
          timeout_nxt = 1'b1;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      req_q      <= '0;
      tx_data_q  <= 8'h00;
      trmt_q     <= 1'b0;
      clr_q      <= 1'b0;
      resp_q     <= 8'h00;
      resp_rdy_q <= 1'b0;
      timeout_q  <= 1'b0;
      timer_q    <= '0;
    end else begin
      state      <= state_nxt;
      req_q      <= req_nxt;
      tx_data_q  <= tx_data_nxt;
      trmt_q     <= trmt_nxt;
      clr_q      <= clr_nxt;
      resp_q     <= resp_nxt;
      resp_rdy_q <= resp_rdy_nxt;
      timeout_q  <= timeout_nxt;
      timer_q    <= timer_nxt;
    end
  end

  // busy follows the state directly so it drops on the same cycle as resp_rdy/timeout
  assign bus.busy       = (state != IDLE);
  assign bus.tx_data    = tx_data_q;
  assign bus.trmt       = trmt_q;
  assign bus.clr_rx_rdy = clr_q;
  assign bus.resp       = resp_q;
  assign bus.resp_rdy   = resp_rdy_q;
  assign bus.timeout    = timeout_q;

endmodule

// File: tb/tb_cmd_framer.sv
// Scoreboard bench for cmd_framer: stimulus pushes expected events, a negedge monitor pops and compares.
module tb_cmd_framer;
  import cmd_pkg::*;

  localparam int K_BYTE  = 0;
  localparam int K_RESP  = 1;
  localparam int K_STALE = 2;
  localparam int K_TO    = 3;
  localparam int TO_CYC  = 1023;  // 2^10 - 1 with FAST_SIM

  typedef struct {
    int         kind;
    logic [7:0] val;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cmd_framer_if bus ();

  cmd_framer #(.FAST_SIM(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t       expq[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         ncyc     = 0;
  logic [7:0] model_resp = 8'h00;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, ncyc);
    end
  endtask

  task automatic flag(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", nm, ncyc);
  endtask

  task automatic push(input int kind, input logic [7:0] val, input int cyc);
    exp_t e;
    e.kind = kind;
    e.val  = val;
    e.cyc  = cyc;
    expq.push_back(e);
  endtask

  task automatic pop_exp(input int kind, input string nm, output bit ok, output exp_t e);
    ok = 1'b0;
    e  = '{kind: -1, val: 8'h00, cyc: 0};
    if (expq.size() == 0) begin
      flag({nm, " pulse with nothing outstanding"});
    end else begin
      e = expq.pop_front();
      chk({nm, " event kind"}, kind, e.kind);
      ok = (e.kind == kind);
    end
  endtask

  // Monitor: every output pulse must match the head of the scoreboard
  always @(negedge clk) begin
    exp_t e;
    bit   ok;
    ncyc++;
    if (!rst) begin
      if (bus.trmt) begin
        pop_exp(K_BYTE, "trmt", ok, e);
        if (ok) begin
          chk("tx_data", bus.tx_data, e.val);
          chk("busy during trmt", bus.busy, 1'b1);
        end
      end
      if (bus.resp_rdy) begin
        pop_exp(K_RESP, "resp_rdy", ok, e);
        if (ok) begin
          chk("resp", bus.resp, e.val);
          chk("clr_rx_rdy with resp", bus.clr_rx_rdy, 1'b1);
          chk("busy low at resp_rdy", bus.busy, 1'b0);
          chk("timeout low at resp_rdy", bus.timeout, 1'b0);
        end
      end else if (bus.clr_rx_rdy) begin
        pop_exp(K_STALE, "stale clr_rx_rdy", ok, e);
        if (ok) chk("resp kept on stale byte", bus.resp, e.val);
      end
      if (bus.timeout) begin
        pop_exp(K_TO, "timeout", ok, e);
        if (ok) begin
          chk("timeout cycle", ncyc, e.cyc);
          chk("resp kept on timeout", bus.resp, e.val);
          chk("busy low at timeout", bus.busy, 1'b0);
        end
      end
    end
  end

  task automatic wait_trmt(input string nm, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.trmt) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) flag({nm, " trmt never arrived"});
  endtask

  task automatic wait_idle(input int bound, input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (!bus.busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) flag({nm, " busy never dropped"});
  endtask

  // One byte handshake: answer the trmt of byte b with tx_done dly cycles later
  task automatic tx_byte(input int b, input int dly, input bit early, input bit intrude,
                         input int intrude_b, output bit ok);
    wait_trmt("frame", ok);
    if (ok) begin
      if (intrude && b == intrude_b) begin
        bus.snd_cmd = 1'b1;
        bus.cmd     = SET_THRST;
        bus.data    = 16'h00FF;
      end
      if (early) bus.tx_done = 1'b1;  // same cycle as trmt: must be ignored
      @(posedge clk);
      #1;
      bus.snd_cmd = 1'b0;
      bus.tx_done = 1'b0;
      repeat (dly) begin
        @(posedge clk);
        #1;
      end
      bus.tx_done = 1'b1;
      @(posedge clk);
      #1;
      bus.tx_done = 1'b0;
    end
  endtask

  // Full transaction; rdly < 1023 gives a response sampled on timer value rdly+1
  task automatic do_txn(input logic [7:0] c, input logic [15:0] d, input int dly,
                        input bit early, input bit intrude, input int intrude_b,
                        input bit do_resp, input logic [7:0] rb, input int rdly);
    bit ok;
    int entry;
    push(K_BYTE, c, 0);
    push(K_BYTE, d[15:8], 0);
    push(K_BYTE, d[7:0], 0);
    @(posedge clk);
    #1;
    bus.snd_cmd = 1'b1;
    bus.cmd     = c;
    bus.data    = d;
    @(posedge clk);
    #1;
    bus.snd_cmd = 1'b0;
    ok = 1'b1;
    for (int b = 0; b < 3 && ok; b++) tx_byte(b, dly, early, intrude, intrude_b, ok);
    if (!ok) return;
    entry = ncyc + 1;  // first cycle spent waiting for the response
    if (do_resp) begin
      repeat (rdly) begin
        @(posedge clk);
        #1;
      end
      push(K_RESP, rb, 0);
      model_resp = rb;
      bus.rx_rdy  = 1'b1;
      bus.rx_data = rb;
      @(posedge clk);
      #1;
      bus.rx_rdy = 1'b0;
      wait_idle(10, "after response");
    end else begin
      push(K_TO, model_resp, entry + TO_CYC);
      wait_idle(TO_CYC + 50, "after timeout");
    end
  endtask

  task automatic stale_byte(input logic [7:0] v);
    @(posedge clk);
    #1;
    push(K_STALE, model_resp, 0);
    bus.rx_rdy  = 1'b1;
    bus.rx_data = v;
    @(posedge clk);
    #1;
    bus.rx_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int n_to;
    bus.snd_cmd = 1'b0;
    bus.cmd     = 8'h00;
    bus.data    = 16'h0000;
    bus.tx_done = 1'b0;
    bus.rx_rdy  = 1'b0;
    bus.rx_data = 8'h00;

    // Reset values
    repeat (3) @(negedge clk);
    chk("reset busy", bus.busy, 1'b0);
    chk("reset trmt", bus.trmt, 1'b0);
    chk("reset clr_rx_rdy", bus.clr_rx_rdy, 1'b0);
    chk("reset resp_rdy", bus.resp_rdy, 1'b0);
    chk("reset timeout", bus.timeout, 1'b0);
    chk("reset tx_data", bus.tx_data, 8'h00);
    chk("reset resp", bus.resp, 8'h00);
    rst = 1'b0;

    // Basic frame, slow transmitter, positive ack
    do_txn(SET_PITCH, 16'h1234, 19, 1'b0, 1'b0, 0, 1'b1, POS_ACK, 5);
    // New request during TX_HI must be dropped
    do_txn(SET_ROLL, 16'hABCD, 4, 1'b0, 1'b1, 1, 1'b1, POS_ACK, 2);
    // No response: timeout after the full window, resp untouched
    do_txn(SET_YAW, 16'h0102, 1, 1'b0, 1'b0, 0, 1'b0, 8'h00, 0);
    // Response on the cycle the timer goes full; non-ack passed through
    do_txn(CALIBRATE, 16'h0000, 0, 1'b0, 1'b0, 0, 1'b1, 8'h3C, TO_CYC - 1);
    // Stale byte in IDLE
    stale_byte(8'h5A);
    // tx_done coinciding with trmt is ignored
    do_txn(EMER_LAND, 16'hBEEF, 2, 1'b1, 1'b0, 0, 1'b1, POS_ACK, 0);

    // Reset in the middle of TX_HI
    push(K_BYTE, SET_YAW, 0);
    push(K_BYTE, 8'h55, 0);
    @(posedge clk);
    #1;
    bus.snd_cmd = 1'b1;
    bus.cmd     = SET_YAW;
    bus.data    = 16'h5566;
    @(posedge clk);
    #1;
    bus.snd_cmd = 1'b0;
    tx_byte(0, 3, 1'b0, 1'b0, 0, ok);
    wait_trmt("pre-reset", ok);
    repeat (4) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("async rst busy", bus.busy, 1'b0);
    chk("async rst trmt", bus.trmt, 1'b0);
    chk("async rst tx_data", bus.tx_data, 8'h00);
    chk("async rst resp", bus.resp, 8'h00);
    chk("async rst clr_rx_rdy", bus.clr_rx_rdy, 1'b0);
    chk("outstanding at reset", expq.size(), 0);
    expq.delete();
    model_resp = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    do_txn(MTRS_OFF, 16'h0000, 3, 1'b0, 1'b0, 0, 1'b1, POS_ACK, 1);

    // Randomised traffic
    n_to = 0;
    for (int i = 0; i < 30; i++) begin
      logic [7:0]  c;
      logic [15:0] d;
      bit          rsp;
      logic [7:0]  rb;
      c   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(2, 8));
      d   = 16'($urandom);
      rsp = 1'b1;
      if ($urandom_range(0, 9) == 0 && n_to < 2) begin
        rsp = 1'b0;
        n_to++;
      end
      rb = ($urandom_range(0, 1) == 0) ? POS_ACK : 8'($urandom);
      if ($urandom_range(0, 4) == 0) stale_byte(8'($urandom));
      do_txn(c, d, $urandom_range(0, 12), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             $urandom_range(0, 2), rsp, rb, $urandom_range(0, 30));
    end

    repeat (5) @(negedge clk);
    chk("scoreboard drained", expq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
